alu_share_arbiter: RTL

Two-requester round-robin arbiter that time-shares the single 32-bit combinational ALU between the MIPS datapath (port 0) and a second client such as a multi-cycle mult/div or address unit (port 1). It owns the only ALU instance, registers the granted operands, and returns the result with requester ID over a valid/ready response channel with backpressure.

---
 rtl/alu_share_pkg.sv | 19 +
 rtl/alu_share_arbiter_if.sv | 43 ++++
 rtl/alu_share_arbiter_alu.sv | 29 ++
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and ALU op encodings for the ALU share arbiter
package alu_share_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - two request ports and one response channel of the ALU share arbiter
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_op1;
  logic [DATA_W-1:0] req0_op2;
  logic [SEL_W-1:0]  req0_sel;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_op1;
  logic [DATA_W-1:0] req1_op2;
  logic [SEL_W-1:0]  req1_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rel;
  logic              rsp_zero;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_sel,
    input  req0_ready,
    output req1_valid, req1_op1, req1_op2, req1_sel,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_rel, rsp_zero,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_sel,
    output req0_ready,
    input  req1_valid, req1_op1, req1_op2, req1_sel,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_rel, rsp_zero,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - the single combinational MIPS ALU (AND/OR/ADD/SUB/SLT)
module alu_share_arbiter_alu
  import alu_share_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] rel,
  output logic              zero
);

  always_comb begin
    rel = '0;
    case (sel)
      ALU_AND: rel = a & b;
      ALU_OR:  rel = a | b;
      ALU_ADD: rel = a + b;
      ALU_SUB: rel = a - b;
      ALU_SLT: rel = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: rel = '0;
    endcase
  end

  assign zero = (rel == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters; ALU_SHARE_FAST_EN drops the EXEC stage
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  logic              rr_ptr_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_rel_q;
  logic              rsp_zero_q;

  logic              gnt0, gnt1;
  logic              ready0, ready1;
  logic              accept;
  logic              rsp_done;

  logic [DATA_W-1:0] alu_a, alu_b, alu_rel;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_zero;

  // On contention rr_ptr picks the winner; a lone requester always wins.
  assign gnt0     = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
  assign gnt1     = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
  assign ready0   = (state_q == IDLE) & gnt0;
  assign ready1   = (state_q == IDLE) & gnt1;
  assign accept   = ready0 | ready1;
  assign rsp_done = (state_q == RESP) & rsp_valid_q & bus.rsp_ready;

`ifdef ALU_SHARE_FAST_EN
  assign alu_a   = ready1 ? bus.req1_op1 : bus.req0_op1;
  assign alu_b   = ready1 ? bus.req1_op2 : bus.req0_op2;
  assign alu_sel = ready1 ? bus.req1_sel : bus.req0_sel;
`else
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [SEL_W-1:0]  sel_q;
  logic              id_q;

  assign alu_a   = op1_q;
  assign alu_b   = op2_q;
  assign alu_sel = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      sel_q <= '0;
      id_q  <= 1'b0;
    end else if (accept) begin
      op1_q <= ready1 ? bus.req1_op1 : bus.req0_op1;
      op2_q <= ready1 ? bus.req1_op2 : bus.req0_op2;
      sel_q <= ready1 ? bus.req1_sel : bus.req0_sel;
      id_q  <= ready1;
    end
  end
`endif

  alu_share_arbiter_alu #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .sel  (alu_sel),
    .rel  (alu_rel),
    .zero (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SHARE_FAST_EN
          state_d = RESP;
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rel_q   <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef ALU_SHARE_FAST_EN
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= ready1;
        rsp_rel_q   <= alu_rel;
        rsp_zero_q  <= alu_zero;
      end
`else
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_rel_q   <= alu_rel;
        rsp_zero_q  <= alu_zero;
      end
`endif
      // The port just served loses priority for the next contention.
      if (rsp_done) begin
        rsp_valid_q <= 1'b0;
        rr_ptr_q    <= ~rsp_id_q;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_rel    = rsp_rel_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule
